tulip_dsp_prog_sequencer: RTL and testbench



---
 rtl/tulip_pkg.sv | 35 +++
 rtl/tulip_dsp_prog_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_tulip_dsp_prog_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tulip_pkg.sv
// rtl/tulip_pkg.sv - shared types for the tulip DSP programming sequencer
package tulip_pkg;

    typedef enum logic [1:0] {
        TGT_LUT     = 2'd0,
        TGT_FIR     = 2'd1,
        TGT_REVERB  = 2'd2,
        TGT_INVALID = 2'd3
    } target_t;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_BYPASS_SETTLE = 3'd1,
        ST_HOLD_RESET    = 3'd2,
        ST_PROGRAM       = 3'd3,
        ST_WAIT_DONE     = 3'd4
    } state_t;

    // Tap-programmed stages (user FIR, reverb) only take the low bits of a beat
    localparam int TAP_WIDTH = 16;

    // Force-bypass vector bit for a stage: [0]=LUT, [1]=FIR, [2]=reverb
    function automatic logic [2:0] target_onehot(input target_t t);
        logic [2:0] oh;
        oh = 3'b000;
        case (t)
            TGT_LUT:    oh = 3'b001;
            TGT_FIR:    oh = 3'b010;
            TGT_REVERB: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tulip_dsp_prog_sequencer.sv
// rtl/tulip_dsp_prog_sequencer.sv - bypass, soft-reset and coefficient-stream sequencer for tulip DSP stages
module tulip_dsp_prog_sequencer
    import tulip_pkg::*;
#(
    parameter int G_DWIDTH       = 24,
    parameter int G_LEN_WIDTH    = 16,
    parameter int G_RESET_CYCLES = 4,
    parameter int G_TIMEOUT      = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             target,
    input  logic [G_LEN_WIDTH-1:0] prog_len,
    input  logic [G_DWIDTH-1:0]    cfg_din,
    input  logic                   cfg_din_valid,
    output logic                   cfg_din_ready,
    input  logic                   user_bypass_lut,
    input  logic                   user_bypass_fir,
    input  logic                   user_bypass_reverb,
    output logic                   bypass_lut,
    output logic                   bypass_fir,
    output logic                   bypass_reverb,
    output logic                   lut_sw_resetn,
    output logic                   fir_sw_resetn,
    output logic                   reverb_sw_resetn,
    output logic [G_DWIDTH-1:0]    lut_prog_din,
    output logic                   lut_prog_valid,
    input  logic                   lut_prog_ready,
    input  logic                   lut_prog_done,
    output logic [TAP_WIDTH-1:0]   fir_prog_din,
    output logic                   fir_prog_valid,
    input  logic                   fir_prog_ready,
    input  logic                   fir_prog_done,
    output logic [TAP_WIDTH-1:0]   reverb_prog_din,
    output logic                   reverb_prog_valid,
    input  logic                   reverb_prog_ready,
    input  logic                   reverb_prog_done,
    output logic                   busy,
    output logic                   seq_done,
    output logic                   seq_error
);

    // One counter serves both the soft-reset hold and the done timeout
    localparam int CNT_MAX = (G_TIMEOUT > G_RESET_CYCLES) ? G_TIMEOUT : G_RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    target_t                tgt_q, tgt_d;
    logic [G_LEN_WIDTH-1:0] len_q, len_d;
    logic [G_LEN_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             force_q, force_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   sel_ready;
    logic                   sel_done;
    logic                   prog_active;
    logic                   beat_hs;

    // Route the selected stage's handshake and done flag back to the sequencer
    always_comb begin
        sel_ready = 1'b0;
        sel_done  = 1'b0;
        case (tgt_q)
            TGT_LUT: begin
                sel_ready = lut_prog_ready;
                sel_done  = lut_prog_done;
            end
            TGT_FIR: begin
                sel_ready = fir_prog_ready;
                sel_done  = fir_prog_done;
            end
            TGT_REVERB: begin
                sel_ready = reverb_prog_ready;
                sel_done  = reverb_prog_done;
            end
            default: begin
                sel_ready = 1'b0;
                sel_done  = 1'b0;
            end
        endcase
    end

    // The stream is open only while beats remain; extra beats are back-pressured
    assign prog_active   = (state_q == ST_PROGRAM) && (beat_q < len_q);
    assign cfg_din_ready = prog_active && sel_ready;
    assign beat_hs       = cfg_din_ready && cfg_din_valid;

    assign lut_prog_din      = cfg_din;
    assign fir_prog_din      = cfg_din[TAP_WIDTH-1:0];
    assign reverb_prog_din   = cfg_din[TAP_WIDTH-1:0];
    assign lut_prog_valid    = prog_active && (tgt_q == TGT_LUT)    && cfg_din_valid;
    assign fir_prog_valid    = prog_active && (tgt_q == TGT_FIR)    && cfg_din_valid;
    assign reverb_prog_valid = prog_active && (tgt_q == TGT_REVERB) && cfg_din_valid;

    assign lut_sw_resetn    = !((state_q == ST_HOLD_RESET) && (tgt_q == TGT_LUT));
    assign fir_sw_resetn    = !((state_q == ST_HOLD_RESET) && (tgt_q == TGT_FIR));
    assign reverb_sw_resetn = !((state_q == ST_HOLD_RESET) && (tgt_q == TGT_REVERB));

    assign bypass_lut    = user_bypass_lut    | force_q[0];
    assign bypass_fir    = user_bypass_fir    | force_q[1];
    assign bypass_reverb = user_bypass_reverb | force_q[2];

    assign busy      = (state_q != ST_IDLE);
    assign seq_done  = done_q;
    assign seq_error = err_q;

    // Next-state logic: settle bypass, hold soft reset, stream beats, await done
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        force_d = force_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (target == TGT_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d   = target_t'(target);
                        len_d   = prog_len;
                        beat_d  = '0;
                        cnt_d   = '0;
                        force_d = target_onehot(target_t'(target));
                        state_d = ST_BYPASS_SETTLE;
                    end
                end
            end
            ST_BYPASS_SETTLE: begin
                cnt_d   = '0;
                state_d = ST_HOLD_RESET;
            end
            ST_HOLD_RESET: begin
                if (cnt_q == CNT_W'(G_RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? ST_WAIT_DONE : ST_PROGRAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PROGRAM: begin
                if (beat_q >= len_q) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (beat_hs) begin
                    beat_d = beat_q + G_LEN_WIDTH'(1);
                    if ((beat_q + G_LEN_WIDTH'(1)) == len_q) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (sel_done) begin
                    force_d = 3'b000;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(G_TIMEOUT - 1)) begin
                    force_d = 3'b000;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                force_d = 3'b000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and sequencing registers; reset abandons any sequence without a pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_LUT;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            force_q <= 3'b000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tulip_dsp_prog_sequencer.sv
// tb/tb_tulip_dsp_prog_sequencer.sv - directed self-checking bench for tulip_dsp_prog_sequencer
module tb_tulip_dsp_prog_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  target;
    logic [15:0] prog_len;
    logic [23:0] cfg_din;
    logic        cfg_din_valid;
    logic        cfg_din_ready;
    logic        user_bypass_lut, user_bypass_fir, user_bypass_reverb;
    logic        bypass_lut, bypass_fir, bypass_reverb;
    logic        lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn;
    logic [23:0] lut_prog_din;
    logic        lut_prog_valid, lut_prog_ready, lut_prog_done;
    logic [15:0] fir_prog_din;
    logic        fir_prog_valid, fir_prog_ready, fir_prog_done;
    logic [15:0] reverb_prog_din;
    logic        reverb_prog_valid, reverb_prog_ready, reverb_prog_done;
    logic        busy, seq_done, seq_error;

    int n_checks = 0;
    int n_fail   = 0;

    tulip_dsp_prog_sequencer #(
        .G_DWIDTH(24), .G_LEN_WIDTH(16), .G_RESET_CYCLES(4), .G_TIMEOUT(4096)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .target(target), .prog_len(prog_len),
        .cfg_din(cfg_din), .cfg_din_valid(cfg_din_valid), .cfg_din_ready(cfg_din_ready),
        .user_bypass_lut(user_bypass_lut), .user_bypass_fir(user_bypass_fir),
        .user_bypass_reverb(user_bypass_reverb),
        .bypass_lut(bypass_lut), .bypass_fir(bypass_fir), .bypass_reverb(bypass_reverb),
        .lut_sw_resetn(lut_sw_resetn), .fir_sw_resetn(fir_sw_resetn),
        .reverb_sw_resetn(reverb_sw_resetn),
        .lut_prog_din(lut_prog_din), .lut_prog_valid(lut_prog_valid),
        .lut_prog_ready(lut_prog_ready), .lut_prog_done(lut_prog_done),
        .fir_prog_din(fir_prog_din), .fir_prog_valid(fir_prog_valid),
        .fir_prog_ready(fir_prog_ready), .fir_prog_done(fir_prog_done),
        .reverb_prog_din(reverb_prog_din), .reverb_prog_valid(reverb_prog_valid),
        .reverb_prog_ready(reverb_prog_ready), .reverb_prog_done(reverb_prog_done),
        .busy(busy), .seq_done(seq_done), .seq_error(seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input int i);
        return 24'(i * 32'h0131B7 + 32'h5A5A01);
    endfunction

    task automatic idle_inputs();
        start = 0; target = 0; prog_len = 0; cfg_din = 0; cfg_din_valid = 0;
        user_bypass_lut = 0; user_bypass_fir = 0; user_bypass_reverb = 0;
        lut_prog_ready = 0; lut_prog_done = 0; fir_prog_ready = 0; fir_prog_done = 0;
        reverb_prog_ready = 0; reverb_prog_done = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if ({seq_done, seq_error} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {seq_done, seq_error}); end
        n_checks++; if (cfg_din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", cfg_din_ready); end
        n_checks++; if ({lut_prog_valid, fir_prog_valid, reverb_prog_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {lut_prog_valid, fir_prog_valid, reverb_prog_valid}); end
        n_checks++; if ({lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn} !== 3'b111) begin n_fail++; $display("FAIL reset_swrst: got %b want 111", {lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn}); end
        n_checks++; if ({bypass_lut, bypass_fir, bypass_reverb} !== 3'b000) begin n_fail++; $display("FAIL reset_bypass: got %b want 000", {bypass_lut, bypass_fir, bypass_reverb}); end
    endtask

    task automatic test_fir_program();
        int hs = 0, last_hs = -10, first_hs = -1, first_low = -1, low_cnt = 0;
        int byp_bad = 0, held_bad = 0, din_bad = 0, other_bad = 0, err_seen = 0, done_cyc = -1;
        logic [23:0] w;
        @(negedge clk);
        start = 1; target = 2'd1; prog_len = 16'd129; fir_prog_ready = 1;
        #1;
        n_checks++; if ({busy, bypass_fir} !== 2'b00) begin n_fail++; $display("FAIL fir_pre_start: got %b want 00", {busy, bypass_fir}); end
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 0;
            w = pat(hs);
            cfg_din = w; cfg_din_valid = 1;
            fir_prog_done = (hs == 129) && (cyc >= last_hs + 3);
            #1;
            if (!fir_sw_resetn) begin low_cnt++; if (first_low < 0) first_low = cyc; end
            if (!lut_sw_resetn || !reverb_sw_resetn || lut_prog_valid || reverb_prog_valid) other_bad++;
            if (seq_error) err_seen++;
            if (hs == 129 && cfg_din_ready) held_bad++;
            if (seq_done) begin
                done_cyc = cyc;
                n_checks++; if ({busy, bypass_fir} !== 2'b00) begin n_fail++; $display("FAIL fir_done_state: busy,bypass got %b want 00", {busy, bypass_fir}); end
                break;
            end
            if (bypass_fir !== 1'b1 || busy !== 1'b1) byp_bad++;
            if (cfg_din_valid && cfg_din_ready) begin
                if (fir_prog_valid !== 1'b1 || fir_prog_din !== w[15:0]) din_bad++;
                if (first_hs < 0) first_hs = cyc;
                hs++; last_hs = cyc;
            end
        end
        cfg_din_valid = 0; fir_prog_done = 0; fir_prog_ready = 0;
        n_checks++; if (hs !== 129) begin n_fail++; $display("FAIL fir_beats: got %0d want 129", hs); end
        n_checks++; if (first_low !== 2) begin n_fail++; $display("FAIL fir_rst_start: got cycle %0d want 2", first_low); end
        n_checks++; if (low_cnt !== 4) begin n_fail++; $display("FAIL fir_rst_len: got %0d want 4", low_cnt); end
        n_checks++; if (first_hs !== 6) begin n_fail++; $display("FAIL fir_first_beat: got cycle %0d want 6", first_hs); end
        n_checks++; if (din_bad !== 0) begin n_fail++; $display("FAIL fir_data: got %0d bad beats want 0", din_bad); end
        n_checks++; if (byp_bad !== 0) begin n_fail++; $display("FAIL fir_bypass_busy: got %0d bad cycles want 0", byp_bad); end
        n_checks++; if (held_bad !== 0) begin n_fail++; $display("FAIL fir_beat130_held: got %0d ready cycles want 0", held_bad); end
        n_checks++; if (other_bad !== 0) begin n_fail++; $display("FAIL fir_other_stages: got %0d bad cycles want 0", other_bad); end
        n_checks++; if (done_cyc !== last_hs + 4) begin n_fail++; $display("FAIL fir_done_time: got cycle %0d want %0d", done_cyc, last_hs + 4); end
        n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL fir_no_error: got %0d want 0", err_seen); end
        @(negedge clk); #1;
        n_checks++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL fir_done_pulse_width: got %0b want 0", seq_done); end
    endtask

    task automatic test_lut_random();
        int hs = 0, last_hs = -1, low_cnt = 0, other_bad = 0, din_bad = 0, rdy_bad = 0, byp_bad = 0, done_cyc = -1;
        @(negedge clk);
        start = 1; target = 2'd0; prog_len = 16'd1024;
        for (int cyc = 1; cyc <= 8000; cyc++) begin
            @(negedge clk);
            start = 0;
            cfg_din_valid = ($urandom_range(0, 3) != 0);
            lut_prog_ready = ($urandom_range(0, 3) != 0);
            cfg_din = cfg_din_valid ? pat(hs + 7) : 24'hFFFFFF;
            lut_prog_done = (hs == 1024);
            #1;
            if (!lut_sw_resetn) low_cnt++;
            if (!fir_sw_resetn || !reverb_sw_resetn || fir_prog_valid || reverb_prog_valid) other_bad++;
            if (!lut_prog_ready && cfg_din_ready) rdy_bad++;
            if (seq_done) begin done_cyc = cyc; break; end
            if (bypass_lut !== 1'b1) byp_bad++;
            if (cfg_din_valid && cfg_din_ready) begin
                if (lut_prog_valid !== 1'b1 || lut_prog_din !== pat(hs + 7)) din_bad++;
                hs++; last_hs = cyc;
            end
        end
        cfg_din_valid = 0; lut_prog_ready = 0; lut_prog_done = 0;
        n_checks++; if (hs !== 1024) begin n_fail++; $display("FAIL lut_beats: got %0d want 1024", hs); end
        n_checks++; if (din_bad !== 0) begin n_fail++; $display("FAIL lut_data_order: got %0d bad words want 0", din_bad); end
        n_checks++; if (low_cnt !== 4) begin n_fail++; $display("FAIL lut_rst_len: got %0d want 4", low_cnt); end
        n_checks++; if (other_bad !== 0) begin n_fail++; $display("FAIL lut_other_stages: got %0d bad cycles want 0", other_bad); end
        n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL lut_ready_follow: got %0d bad cycles want 0", rdy_bad); end
        n_checks++; if (byp_bad !== 0) begin n_fail++; $display("FAIL lut_bypass_busy: got %0d bad cycles want 0", byp_bad); end
        n_checks++; if (done_cyc !== last_hs + 2) begin n_fail++; $display("FAIL lut_done_time: got cycle %0d want %0d", done_cyc, last_hs + 2); end
    endtask

    task automatic test_invalid_target();
        @(negedge clk);
        user_bypass_fir = 1;
        start = 1; target = 2'd3; prog_len = 16'd5;
        #1;
        n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL inv_early_error: got %0b want 0", seq_error); end
        @(negedge clk);
        start = 0;
        #1;
        n_checks++; if ({seq_error, seq_done, busy} !== 3'b100) begin n_fail++; $display("FAIL inv_error_pulse: err,done,busy got %b want 100", {seq_error, seq_done, busy}); end
        n_checks++; if ({lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn} !== 3'b111) begin n_fail++; $display("FAIL inv_swrst: got %b want 111", {lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn}); end
        n_checks++; if ({bypass_lut, bypass_fir, bypass_reverb} !== 3'b010) begin n_fail++; $display("FAIL inv_bypass: got %b want 010", {bypass_lut, bypass_fir, bypass_reverb}); end
        @(negedge clk); #1;
        n_checks++; if ({seq_error, busy} !== 2'b00) begin n_fail++; $display("FAIL inv_pulse_width: err,busy got %b want 00", {seq_error, busy}); end
        user_bypass_fir = 0;
    endtask

    task automatic test_timeout();
        int hs = 0, last_hs = -1, low_cnt = 0, err_cyc = -1, done_seen = 0, byp_bad = 0;
        @(negedge clk);
        start = 1; target = 2'd2; prog_len = 16'd64; reverb_prog_ready = 1;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            @(negedge clk);
            start = 0;
            cfg_din = pat(hs + 300); cfg_din_valid = 1;
            #1;
            if (!reverb_sw_resetn) low_cnt++;
            if (seq_done) done_seen++;
            if (seq_error) begin
                err_cyc = cyc;
                n_checks++; if ({busy, bypass_reverb} !== 2'b00) begin n_fail++; $display("FAIL tmo_exit_state: busy,bypass got %b want 00", {busy, bypass_reverb}); end
                break;
            end
            if (bypass_reverb !== 1'b1) byp_bad++;
            if (cfg_din_valid && cfg_din_ready) begin hs++; last_hs = cyc; end
        end
        cfg_din_valid = 0; reverb_prog_ready = 0;
        n_checks++; if (hs !== 64) begin n_fail++; $display("FAIL tmo_beats: got %0d want 64", hs); end
        n_checks++; if (low_cnt !== 4) begin n_fail++; $display("FAIL tmo_rst_len: got %0d want 4", low_cnt); end
        n_checks++; if (err_cyc !== last_hs + 4097) begin n_fail++; $display("FAIL tmo_error_time: got cycle %0d want %0d", err_cyc, last_hs + 4097); end
        n_checks++; if ((done_seen !== 0) || (byp_bad !== 0)) begin n_fail++; $display("FAIL tmo_done_or_bypass: got done=%0d bad_bypass=%0d want 0/0", done_seen, byp_bad); end
        @(negedge clk);
        user_bypass_reverb = 1;
        #1;
        n_checks++; if (bypass_reverb !== 1'b1) begin n_fail++; $display("FAIL tmo_user_bypass: got %0b want 1", bypass_reverb); end
        user_bypass_reverb = 0;
    endtask

    task automatic test_reset_mid_program();
        int hs = 0;
        @(negedge clk);
        start = 1; target = 2'd1; prog_len = 16'd50; fir_prog_ready = 1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start = 0;
            cfg_din = pat(hs); cfg_din_valid = 1;
            #1;
            if (cfg_din_valid && cfg_din_ready) hs++;
            if (hs == 10) break;
        end
        n_checks++; if (hs !== 10) begin n_fail++; $display("FAIL rst_mid_reach: got %0d beats want 10", hs); end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        n_checks++; if ({busy, seq_done, seq_error, cfg_din_ready} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_status: busy,done,err,ready got %b want 0000", {busy, seq_done, seq_error, cfg_din_ready}); end
        n_checks++; if ({lut_prog_valid, fir_prog_valid, reverb_prog_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_valids: got %b want 000", {lut_prog_valid, fir_prog_valid, reverb_prog_valid}); end
        n_checks++; if ({lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn, bypass_fir} !== 4'b1110) begin n_fail++; $display("FAIL rst_mid_rst_bypass: got %b want 1110", {lut_sw_resetn, fir_sw_resetn, reverb_sw_resetn, bypass_fir}); end
        @(negedge clk); #1;
        n_checks++; if ({busy, seq_done, seq_error} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_no_pulse: got %b want 000", {busy, seq_done, seq_error}); end
        cfg_din_valid = 0; fir_prog_ready = 0;
    endtask

    task automatic test_len_zero();
        int ready_seen = 0, low_cnt = 0, done_cyc = -1;
        @(negedge clk);
        fir_prog_done = 1; fir_prog_ready = 1; cfg_din_valid = 1; cfg_din = 24'h123456;
        start = 1; target = 2'd1; prog_len = 16'd0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 0;
            #1;
            if (cfg_din_ready || fir_prog_valid) ready_seen++;
            if (!fir_sw_resetn) low_cnt++;
            if (seq_done) begin done_cyc = cyc; break; end
        end
        fir_prog_done = 0; fir_prog_ready = 0; cfg_din_valid = 0;
        n_checks++; if (done_cyc !== 7) begin n_fail++; $display("FAIL len0_done_time: got cycle %0d want 7", done_cyc); end
        n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL len0_no_handshake: got %0d cycles want 0", ready_seen); end
        n_checks++; if (low_cnt !== 4) begin n_fail++; $display("FAIL len0_rst_len: got %0d want 4", low_cnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fir_program();
        test_lut_random();
        test_invalid_target();
        test_timeout();
        test_reset_mid_program();
        test_len_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
